// File: rtl/crc_ser_feed_if.sv
// crc_ser_feed_if: ICB register port plus the serial feed toward the CRC engine.
interface crc_ser_feed_if;
    logic        icb_wr;
    logic [7:0]  icb_wadr;
    logic [31:0] icb_wdat;
    logic        icb_wack;
    logic        icb_rd;
    logic [7:0]  icb_radr;
    logic [31:0] icb_rdat;
    logic        icb_rack;
    logic        ser_dat;
    logic        ser_vld;
    logic        ser_crc_en;
    logic        ser_sof;
    logic        ser_eof;
    modport master(
        output icb_wr, icb_wadr, icb_wdat, icb_rd, icb_radr,
        input  icb_wack, icb_rdat, icb_rack, ser_dat, ser_vld, ser_crc_en, ser_sof, ser_eof
    );
    modport slave(
        input  icb_wr, icb_wadr, icb_wdat, icb_rd, icb_radr,
        output icb_wack, icb_rdat, icb_rack, ser_dat, ser_vld, ser_crc_en, ser_sof, ser_eof
    );
endinterface

// File: rtl/crc_ser_feed.sv
// crc_ser_feed: byte FIFO fed over ICB, serialized one bit per cycle with CRC framing qualifiers.
module crc_ser_feed #(
    parameter int FIFO_AW = 2
) (
    input  logic           clk,
    input  logic           rst,
    crc_ser_feed_if.slave  bus,
    output logic           irq
);
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STALL, GAP} state_t;
    state_t st;
    logic en, skip, lsb, irq_en, und, ovf, done, f_skip, f_lsb;
    logic [7:0] len, f_len, byte_cnt, sreg, head, src, nxt_byte;
    logic [2:0] bit_cnt;
    logic [7:0] mem [2**FIFO_AW];
    logic [FIFO_AW-1:0] wp, rp;
    logic [FIFO_AW:0] cnt;
    logic con_wr, dat_wr, stat_wr, push, pop, full, empty, abort, end_bit, last, go, unused_ok;

    assign bus.icb_wack = bus.icb_wr;
    assign bus.icb_rack = bus.icb_rd;
    assign con_wr = bus.icb_wr && bus.icb_wadr == 8'd0;
    assign dat_wr = bus.icb_wr && bus.icb_wadr == 8'd1;
    assign stat_wr = bus.icb_wr && bus.icb_wadr == 8'd2;
    assign full = cnt[FIFO_AW];
    assign empty = cnt == '0;
    assign push = dat_wr && !full;
    assign end_bit = st == SHIFT && bit_cnt == 3'd7;
    assign last = byte_cnt == f_len - 8'd1;
    assign abort = con_wr && !bus.icb_wdat[0] && st != IDLE;
    assign pop = st == LOAD || (end_bit && !last && !empty);
    // go: a bit is presented next cycle, either mid-byte or from a freshly popped byte
    assign go = pop || (st == SHIFT && !end_bit);
    assign head = mem[rp];
    assign src = (st == SHIFT && !end_bit) ? sreg : head;
    assign nxt_byte = end_bit ? byte_cnt + 8'd1 : byte_cnt;
    assign irq = irq_en && (und || ovf || done);
    assign unused_ok = ^bus.icb_wdat[31:16];
    assign bus.icb_rdat = bus.icb_radr == 8'd0 ? {16'd0, len, 4'd0, irq_en, lsb, skip, en} :
                          bus.icb_radr == 8'd2 ? (32'(cnt) << 8) | {28'd0, done, ovf, und, st != IDLE} :
                          32'd0;

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= bus.icb_wdat[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            wp <= wp + FIFO_AW'(push);
            rp <= rp + FIFO_AW'(pop);
            cnt <= cnt + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        end
    end

    // sticky bits: a set event in the same cycle as a W1C clear wins
    always_ff @(posedge clk) begin
        if (rst) begin
            {len, irq_en, lsb, skip, en} <= '0;
            {und, ovf, done} <= '0;
        end else begin
            if (con_wr) {len, irq_en, lsb, skip, en} <= {bus.icb_wdat[15:8], bus.icb_wdat[3:0]};
            und <= (und && !(stat_wr && bus.icb_wdat[1])) || (end_bit && !last && empty && !abort);
            ovf <= (ovf && !(stat_wr && bus.icb_wdat[2])) || (dat_wr && full);
            done <= (done && !(stat_wr && bus.icb_wdat[3])) || (end_bit && last && !abort);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            st <= IDLE;
            {f_len, f_skip, f_lsb, byte_cnt, bit_cnt, sreg} <= '0;
            {bus.ser_dat, bus.ser_vld, bus.ser_crc_en, bus.ser_sof, bus.ser_eof} <= '0;
        end else begin
            bus.ser_vld <= go;
            bus.ser_dat <= go && (f_lsb ? src[0] : src[7]);
            bus.ser_sof <= st == LOAD && byte_cnt == 8'd0;
            bus.ser_eof <= st == SHIFT && bit_cnt == 3'd6 && last;
            bus.ser_crc_en <= go && !(f_skip && nxt_byte == 8'd0);
            if (go) sreg <= f_lsb ? src >> 1 : src << 1;
            bit_cnt <= (st == SHIFT && !end_bit) ? bit_cnt + 3'd1 : 3'd0;
            byte_cnt <= st == IDLE ? 8'd0 : (end_bit && !last) ? byte_cnt + 8'd1 : byte_cnt;
            if (st == IDLE && en && !empty) {f_len, f_skip, f_lsb} <= {len, skip, lsb};
            case (st)
                IDLE:    st <= (en && !empty) ? LOAD : IDLE;
                LOAD:    st <= SHIFT;
                SHIFT:   st <= !end_bit ? SHIFT : last ? GAP : empty ? STALL : SHIFT;
                STALL:   st <= empty ? STALL : LOAD;
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_crc_ser_feed.sv
// tb_crc_ser_feed: directed scenarios with hand-computed bit streams and register values.
module tb_crc_ser_feed;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq;
    int vec = 0;
    int errs = 0;
    int cyc = 0;
    int viol = 0;
    logic bq[$], cq[$], sq[$], eq[$];
    int tq[$];

    always #5 clk = ~clk;

    crc_ser_feed_if bus();
    crc_ser_feed #(.FIFO_AW(2)) dut(.clk(clk), .rst(rst), .bus(bus), .irq(irq));

    always @(negedge clk) begin
        cyc++;
        if (bus.ser_vld === 1'b1) begin
            bq.push_back(bus.ser_dat);
            cq.push_back(bus.ser_crc_en);
            sq.push_back(bus.ser_sof);
            eq.push_back(bus.ser_eof);
            tq.push_back(cyc);
        end else if ((bus.ser_dat | bus.ser_crc_en | bus.ser_sof | bus.ser_eof) !== 1'b0) viol++;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got still running, expected finished");
        $fatal(1);
    end

    function automatic logic [31:0] pack(input logic q[$]);
        logic [31:0] v = '0;
        foreach (q[i]) v = {v[30:0], q[i]};
        return v;
    endfunction

    function automatic int ones(input logic q[$]);
        int n = 0;
        foreach (q[i]) n += int'(q[i]);
        return n;
    endfunction

    task automatic clear_mon();
        bq.delete(); cq.delete(); sq.delete(); eq.delete(); tq.delete();
        viol = 0;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.icb_wr = 1'b1; bus.icb_wadr = a; bus.icb_wdat = d;
        @(negedge clk);
        bus.icb_wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.icb_rd = 1'b1; bus.icb_radr = a;
        #1 d = bus.icb_rdat;
        bus.icb_rd = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        logic [31:0] s;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            rd_reg(8'd2, s);
            if (s[0] === 1'b0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        logic [31:0] s;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vec++;
        if ({bus.ser_dat, bus.ser_vld, bus.ser_crc_en, bus.ser_sof, bus.ser_eof, irq} !== 6'b0) begin
            errs++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {bus.ser_dat, bus.ser_vld, bus.ser_crc_en, bus.ser_sof, bus.ser_eof, irq});
        end
        rst = 1'b0;
        rd_reg(8'd0, s);
        vec++; if (s !== 32'd0) begin errs++; $display("FAIL reset_con: got %h expected 0", s); end
        rd_reg(8'd2, s);
        vec++; if (s !== 32'd0) begin errs++; $display("FAIL reset_stat: got %h expected 0", s); end
        rd_reg(8'd1, s);
        vec++; if (s !== 32'd0) begin errs++; $display("FAIL txdat_read: got %h expected 0", s); end
        @(negedge clk);
        bus.icb_wr = 1'b1; bus.icb_wadr = 8'h07; bus.icb_wdat = 32'hFFFF_FFFF;
        bus.icb_rd = 1'b1; bus.icb_radr = 8'h05;
        #1;
        vec++;
        if ({bus.icb_wack, bus.icb_rack} !== 2'b11) begin
            errs++; $display("FAIL acks: got %b expected 11", {bus.icb_wack, bus.icb_rack});
        end
        vec++; if (bus.icb_rdat !== 32'd0) begin errs++; $display("FAIL unmapped_read: got %h expected 0", bus.icb_rdat); end
        @(negedge clk);
        bus.icb_wr = 1'b0; bus.icb_rd = 1'b0;
    endtask

    task automatic test_msb_frame();
        logic [31:0] s;
        bit ok;
        clear_mon();
        wr_reg(8'd1, 32'hA5); wr_reg(8'd1, 32'h01); wr_reg(8'd1, 32'hFF);
        wr_reg(8'd0, 32'h0301);
        wait_idle(200, ok);
        vec++; if (!ok) begin errs++; $display("FAIL msb_idle: got busy expected idle"); end
        vec++; if (bq.size() != 24) begin errs++; $display("FAIL msb_len: got %0d expected 24", bq.size()); end
        vec++; if (pack(bq) !== 32'h00A501FF) begin errs++; $display("FAIL msb_bits: got %h expected 00a501ff", pack(bq)); end
        vec++;
        if (!(tq.size() == 24 && tq[23] - tq[0] == 23)) begin errs++; $display("FAIL msb_contig: got %0d bits not contiguous expected 24 contiguous", tq.size()); end
        vec++; if (pack(sq) !== 32'h00800000) begin errs++; $display("FAIL msb_sof: got %h expected 00800000", pack(sq)); end
        vec++; if (pack(eq) !== 32'h1) begin errs++; $display("FAIL msb_eof: got %h expected 1", pack(eq)); end
        vec++; if (ones(cq) != 24) begin errs++; $display("FAIL msb_crc_en: got %0d expected 24", ones(cq)); end
        vec++; if (viol != 0) begin errs++; $display("FAIL msb_idle_outputs: got %0d expected 0", viol); end
        rd_reg(8'd2, s);
        vec++; if (s[10:0] !== 11'h008) begin errs++; $display("FAIL msb_stat: got %h expected 008", s[10:0]); end
        wr_reg(8'd0, 32'h0); wr_reg(8'd2, 32'h8);
        rd_reg(8'd2, s);
        vec++; if (s !== 32'd0) begin errs++; $display("FAIL done_w1c: got %h expected 0", s); end
    endtask

    task automatic test_lsb_skip();
        bit ok;
        clear_mon();
        wr_reg(8'd1, 32'h80); wr_reg(8'd1, 32'h3C);
        wr_reg(8'd0, 32'h0207);
        wait_idle(200, ok);
        vec++; if (!ok) begin errs++; $display("FAIL lsb_idle: got busy expected idle"); end
        vec++; if (bq.size() != 16) begin errs++; $display("FAIL lsb_len: got %0d expected 16", bq.size()); end
        vec++; if (pack(bq) !== 32'h013C) begin errs++; $display("FAIL lsb_bits: got %h expected 013c", pack(bq)); end
        vec++; if (pack(cq) !== 32'h00FF) begin errs++; $display("FAIL skip_crc_en: got %h expected 00ff", pack(cq)); end
        vec++; if (pack(sq) !== 32'h8000) begin errs++; $display("FAIL lsb_sof: got %h expected 8000", pack(sq)); end
        vec++; if (pack(eq) !== 32'h1) begin errs++; $display("FAIL lsb_eof: got %h expected 1", pack(eq)); end
        wr_reg(8'd0, 32'h0); wr_reg(8'd2, 32'h8);
    endtask

    task automatic test_overflow();
        logic [31:0] s;
        bit ok;
        wr_reg(8'd1, 32'h11); wr_reg(8'd1, 32'h22); wr_reg(8'd1, 32'h33);
        wr_reg(8'd1, 32'h44); wr_reg(8'd1, 32'h55);
        rd_reg(8'd2, s);
        vec++; if (s[10:0] !== 11'h404) begin errs++; $display("FAIL ovf_stat: got %h expected 404", s[10:0]); end
        vec++; if (irq !== 1'b0) begin errs++; $display("FAIL ovf_irq_off: got %b expected 0", irq); end
        wr_reg(8'd0, 32'h08);
        vec++; if (irq !== 1'b1) begin errs++; $display("FAIL ovf_irq_on: got %b expected 1", irq); end
        wr_reg(8'd2, 32'h4);
        rd_reg(8'd2, s);
        vec++; if (s[10:0] !== 11'h400) begin errs++; $display("FAIL ovf_w1c: got %h expected 400", s[10:0]); end
        vec++; if (irq !== 1'b0) begin errs++; $display("FAIL ovf_irq_clr: got %b expected 0", irq); end
        clear_mon();
        wr_reg(8'd0, 32'h0401);
        wait_idle(200, ok);
        vec++; if (!ok) begin errs++; $display("FAIL drain_idle: got busy expected idle"); end
        vec++;
        if (bq.size() != 32 || pack(bq) !== 32'h11223344) begin
            errs++; $display("FAIL drain_bits: got %0d bits %h expected 32 bits 11223344", bq.size(), pack(bq));
        end
        wr_reg(8'd0, 32'h0408);
        vec++; if (irq !== 1'b1) begin errs++; $display("FAIL done_irq: got %b expected 1", irq); end
        wr_reg(8'd2, 32'h8);
        vec++; if (irq !== 1'b0) begin errs++; $display("FAIL done_irq_clr: got %b expected 0", irq); end
        wr_reg(8'd0, 32'h0);
    endtask

    task automatic test_underrun();
        logic [31:0] s;
        bit ok;
        clear_mon();
        wr_reg(8'd1, 32'hC3);
        wr_reg(8'd0, 32'h0201);
        repeat (20) @(negedge clk);
        vec++; if (bus.ser_vld !== 1'b0) begin errs++; $display("FAIL stall_vld: got %b expected 0", bus.ser_vld); end
        rd_reg(8'd2, s);
        vec++; if (s[3:0] !== 4'b0011) begin errs++; $display("FAIL stall_stat: got %b expected 0011", s[3:0]); end
        wr_reg(8'd1, 32'h5A);
        wait_idle(200, ok);
        vec++; if (!ok) begin errs++; $display("FAIL under_idle: got busy expected idle"); end
        vec++;
        if (bq.size() != 16 || pack(bq) !== 32'hC35A) begin
            errs++; $display("FAIL under_bits: got %0d bits %h expected 16 bits c35a", bq.size(), pack(bq));
        end
        vec++; if (pack(eq) !== 32'h1) begin errs++; $display("FAIL under_eof: got %h expected 1", pack(eq)); end
        vec++; if (pack(sq) !== 32'h8000) begin errs++; $display("FAIL under_sof: got %h expected 8000", pack(sq)); end
        vec++;
        if (!(tq.size() == 16 && tq[8] - tq[7] > 10)) begin errs++; $display("FAIL under_gap: got no stall gap expected gap over 10 cycles"); end
        vec++; if (viol != 0) begin errs++; $display("FAIL under_idle_outputs: got %0d expected 0", viol); end
        rd_reg(8'd2, s);
        vec++; if (s[3:0] !== 4'b1010) begin errs++; $display("FAIL under_stat: got %b expected 1010", s[3:0]); end
        wr_reg(8'd2, 32'hE); wr_reg(8'd0, 32'h0);
    endtask

    task automatic test_abort();
        logic [31:0] s;
        bit seen;
        int n;
        clear_mon();
        wr_reg(8'd1, 32'hF0); wr_reg(8'd1, 32'h0F);
        wr_reg(8'd0, 32'h0401);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ser_vld === 1'b1) begin seen = 1'b1; break; end
        end
        vec++; if (!seen) begin errs++; $display("FAIL abort_start: got no ser_vld expected ser_vld"); end
        repeat (2) @(negedge clk);
        wr_reg(8'd0, 32'h0400);
        vec++; if (bus.ser_vld !== 1'b0) begin errs++; $display("FAIL abort_vld: got %b expected 0", bus.ser_vld); end
        rd_reg(8'd2, s);
        vec++; if (s[10:0] !== 11'h000) begin errs++; $display("FAIL abort_stat: got %h expected 000", s[10:0]); end
        n = bq.size();
        vec++; if (n < 1 || n > 15) begin errs++; $display("FAIL abort_midframe: got %0d bits expected 1..15", n); end
        repeat (20) @(negedge clk);
        vec++; if (bq.size() != n) begin errs++; $display("FAIL abort_quiet: got %0d bits expected %0d", bq.size(), n); end
        vec++; if (ones(eq) != 0) begin errs++; $display("FAIL abort_eof: got %0d expected 0", ones(eq)); end
        wr_reg(8'd0, 32'h0);
    endtask

    task automatic test_len256();
        logic [31:0] s;
        bit ok;
        int i, bad;
        logic [7:0] b;
        clear_mon();
        for (int k = 0; k < 4; k++) wr_reg(8'd1, 32'(k));
        wr_reg(8'd0, 32'h0001);
        i = 4;
        for (int g = 0; g < 6000 && i < 256; g++) begin
            rd_reg(8'd2, s);
            if (s[10:8] < 3'd4) begin wr_reg(8'd1, 32'(i)); i++; end
        end
        vec++; if (i != 256) begin errs++; $display("FAIL feed_256: got %0d expected 256", i); end
        wait_idle(3000, ok);
        vec++; if (!ok) begin errs++; $display("FAIL l256_idle: got busy expected idle"); end
        vec++; if (bq.size() != 2048) begin errs++; $display("FAIL l256_len: got %0d expected 2048", bq.size()); end
        bad = 0;
        foreach (bq[k]) begin
            b = 8'(k >> 3);
            if (bq[k] !== b[7 - (k & 7)]) bad++;
        end
        vec++; if (bad != 0) begin errs++; $display("FAIL l256_bits: got %0d wrong bits expected 0", bad); end
        vec++;
        if (!(tq.size() == 2048 && tq[2047] - tq[0] == 2047)) begin errs++; $display("FAIL l256_contig: got gaps expected 2048 contiguous"); end
        vec++;
        if (!(ones(sq) == 1 && sq.size() > 0 && sq[0] === 1'b1)) begin errs++; $display("FAIL l256_sof: got %0d sofs expected 1 at bit 1", ones(sq)); end
        vec++;
        if (!(ones(eq) == 1 && eq.size() == 2048 && eq[2047] === 1'b1)) begin errs++; $display("FAIL l256_eof: got %0d eofs expected 1 at bit 2048", ones(eq)); end
        vec++; if (ones(cq) != 2048) begin errs++; $display("FAIL l256_crc_en: got %0d expected 2048", ones(cq)); end
        rd_reg(8'd2, s);
        vec++; if (s[10:0] !== 11'h008) begin errs++; $display("FAIL l256_stat: got %h expected 008", s[10:0]); end
        wr_reg(8'd2, 32'h8); wr_reg(8'd0, 32'h0);
    endtask

    initial begin
        bus.icb_wr = 1'b0; bus.icb_wadr = '0; bus.icb_wdat = '0;
        bus.icb_rd = 1'b0; bus.icb_radr = '0;
        test_reset();
        test_msb_frame();
        test_lsb_skip();
        test_overflow();
        test_underrun();
        test_abort();
        test_len256();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
